// File: rtl/spi_ram_arbiter_if.sv
// Signal bundle for spi_ram_arbiter: SPI-slave word stream, local host port and single-port RAM.
// slave is the arbiter's view, master is the surrounding environment's view.
interface spi_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [9:0]        rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic              err_ovf;

  modport slave (
    input  rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_dout,
    output tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
           ram_en, ram_we, ram_addr, ram_din, err_ovf
  );

  modport master (
    output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_dout,
    input  tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
           ram_en, ram_we, ram_addr, ram_din, err_ovf
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Arbitrates SPI-slave commands and a local host port onto one single-port RAM (1-cycle read).
// Define SPI_RAM_ARB_RR_EN for round-robin on contention; by default SPI always wins.
module spi_ram_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  spi_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAcc, StRd} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              pend_q, pend_d;
  logic              pend_we_q, pend_we_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              win_spi_q, win_spi_d;
  logic              acc_we_q, acc_we_d;
  logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
  logic [DATA_W-1:0] acc_din_q, acc_din_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic              err_ovf_q, err_ovf_d;

  logic [1:0] cmd;
  logic [7:0] payload;
  logic       spi_granted;
  logic       pick_spi;

  assign cmd         = bus.rx_data[9:8];
  assign payload     = bus.rx_data[7:0];
  assign spi_granted = (state_q == StAcc) && win_spi_q;

`ifdef SPI_RAM_ARB_RR_EN
  logic last_spi_q, last_spi_d;

  // On contention the side that did not win last time goes first.
  assign pick_spi = pend_q && (!bus.host_req || !last_spi_q);

  always_comb begin
    last_spi_d = last_spi_q;
    if (state_q == StIdle && (pend_q || bus.host_req)) begin
      last_spi_d = pick_spi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_spi_q <= 1'b0;
    end else begin
      last_spi_q <= last_spi_d;
    end
  end
`else
  assign pick_spi = pend_q;
`endif

  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    pend_d        = pend_q;
    pend_we_d     = pend_we_q;
    pend_addr_d   = pend_addr_q;
    pend_data_d   = pend_data_q;
    win_spi_d     = win_spi_q;
    acc_we_d      = acc_we_q;
    acc_addr_d    = acc_addr_q;
    acc_din_d     = acc_din_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = 1'b0;
    host_rdata_d  = host_rdata_q;
    host_rvalid_d = 1'b0;
    err_ovf_d     = err_ovf_q;

    case (state_q)
      StIdle: begin
        if (pend_q || bus.host_req) begin
          win_spi_d = pick_spi;
          if (pick_spi) begin
            acc_we_d   = pend_we_q;
            acc_addr_d = pend_addr_q;
            acc_din_d  = pend_data_q;
          end else begin
            acc_we_d   = bus.host_we;
            acc_addr_d = bus.host_addr;
            acc_din_d  = bus.host_wdata;
          end
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (win_spi_q) begin
          pend_d = 1'b0;
        end
        state_d = acc_we_q ? StIdle : StRd;
      end
      StRd: begin
        if (win_spi_q) begin
          tx_data_d  = bus.ram_dout;
          tx_valid_d = 1'b1;
        end else begin
          host_rdata_d  = bus.ram_dout;
          host_rvalid_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Evaluated after the FSM so a request accepted in the granting cycle survives the clear.
    if (bus.rx_valid) begin
      case (cmd)
        2'b00: wr_addr_d = ADDR_W'(payload);
        2'b10: rd_addr_d = ADDR_W'(payload);
        default: begin
          if (!pend_q || spi_granted) begin
            pend_d      = 1'b1;
            pend_we_d   = !cmd[1];
            pend_addr_d = cmd[1] ? rd_addr_q : wr_addr_q;
            pend_data_d = DATA_W'(payload);
          end else begin
            err_ovf_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      pend_q        <= 1'b0;
      pend_we_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      win_spi_q     <= 1'b0;
      acc_we_q      <= 1'b0;
      acc_addr_q    <= '0;
      acc_din_q     <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      pend_q        <= pend_d;
      pend_we_q     <= pend_we_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
      win_spi_q     <= win_spi_d;
      acc_we_q      <= acc_we_d;
      acc_addr_q    <= acc_addr_d;
      acc_din_q     <= acc_din_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  assign bus.ram_en      = (state_q == StAcc);
  assign bus.ram_we      = (state_q == StAcc) && acc_we_q;
  assign bus.ram_addr    = acc_addr_q;
  assign bus.ram_din     = acc_din_q;
  assign bus.host_gnt    = (state_q == StAcc) && !win_spi_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: RAM model plus scoreboard queues for RAM accesses and read returns.
`timescale 1ns/1ps
module tb_spi_ram_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
`ifdef SPI_RAM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  spi_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Single-port RAM with 1-cycle read latency.
  logic [DW-1:0] mem [256] = '{default: '0};
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
    end
  end

  typedef struct packed {
    logic          host;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } acc_t;

  acc_t          acc_q [$];
  logic [DW-1:0] tx_q [$];
  logic [DW-1:0] hr_q [$];
  logic [DW-1:0] ref_mem [256] = '{default: '0};

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int last_tx_cyc = 0;
  int issue;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_acc(input logic host, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] din);
    acc_t e;
    e = '{host: host, we: we, addr: addr, din: din};
    acc_q.push_back(e);
    if (we) ref_mem[addr] = din;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.host_gnt && !bus.ram_en) check_eq("gnt_outside_acc", 1, 0);
      if (bus.ram_we && !bus.ram_en) check_eq("we_outside_acc", 1, 0);
      if (bus.ram_en) begin : chk_acc
        acc_t e;
        last_acc_cyc = cyc;
        if (acc_q.size() == 0) begin
          check_eq("unexpected_ram_access", {bus.ram_we, bus.ram_addr}, 0);
        end else begin
          e = acc_q.pop_front();
          check_eq("acc_host_gnt", bus.host_gnt, e.host);
          check_eq("acc_we", bus.ram_we, e.we);
          check_eq("acc_addr", bus.ram_addr, e.addr);
          if (e.we) check_eq("acc_din", bus.ram_din, e.din);
        end
      end
      if (bus.tx_valid) begin
        last_tx_cyc = cyc;
        if (tx_q.size() == 0) check_eq("unexpected_tx_valid", bus.tx_data, 0);
        else check_eq("tx_data", bus.tx_data, tx_q.pop_front());
      end
      if (bus.host_rvalid) begin
        if (hr_q.size() == 0) check_eq("unexpected_host_rvalid", bus.host_rdata, 0);
        else check_eq("host_rdata", bus.host_rdata, hr_q.pop_front());
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spi_cmd(input logic [1:0] cmd, input logic [7:0] pl);
    bus.rx_data  = {cmd, pl};
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  // Holds the request until the grant is seen, bounded by a cycle budget.
  task automatic host_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    got            = 1'b0;
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_wdata = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.host_gnt;
    end
    if (!got) check_eq("host_gnt_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.host_req = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ram_en"}, bus.ram_en, 0);
    check_eq({tag, "_ram_we"}, bus.ram_we, 0);
    check_eq({tag, "_host_gnt"}, bus.host_gnt, 0);
    check_eq({tag, "_tx_valid"}, bus.tx_valid, 0);
    check_eq({tag, "_tx_data"}, bus.tx_data, 0);
    check_eq({tag, "_host_rvalid"}, bus.host_rvalid, 0);
    check_eq({tag, "_host_rdata"}, bus.host_rdata, 0);
    check_eq({tag, "_err_ovf"}, bus.err_ovf, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.rx_data    = '0;
    bus.rx_valid   = 1'b0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    #12;
    check_outputs_zero("reset");
    check_eq("reset_ram_addr", bus.ram_addr, 0);
    check_eq("reset_ram_din", bus.ram_din, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);

    // SPI write 0x12 <- 0xA5, ram_en two cycles after the 01 word
    spi_cmd(2'b00, 8'h12);
    exp_acc(1'b0, 1'b1, 8'h12, 8'hA5);
    issue = cyc;
    spi_cmd(2'b01, 8'hA5);
    step(4);
    check_eq("wr_latency", last_acc_cyc - issue, 2);

    // SPI read back, tx_valid three cycles after the decision
    spi_cmd(2'b10, 8'h12);
    exp_acc(1'b0, 1'b0, 8'h12, 8'h00);
    tx_q.push_back(ref_mem[8'h12]);
    issue = cyc;
    spi_cmd(2'b11, 8'hFF);
    step(6);
    check_eq("rd_latency", last_tx_cyc - issue, 4);
    check_eq("tx_data_hold", bus.tx_data, 8'hA5);

    // Contention after reset: last winner is host, so SPI goes first in both builds
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    spi_cmd(2'b00, 8'h40);
    if (!RrEn) begin
      exp_acc(1'b0, 1'b1, 8'h40, 8'h77);
      exp_acc(1'b0, 1'b1, 8'h40, 8'h88);
      exp_acc(1'b1, 1'b1, 8'h34, 8'h5C);
    end else begin
      exp_acc(1'b0, 1'b1, 8'h40, 8'h77);
      exp_acc(1'b1, 1'b1, 8'h34, 8'h5C);
      exp_acc(1'b0, 1'b1, 8'h40, 8'h88);
    end
    fork
      begin
        spi_cmd(2'b01, 8'h77);
        step();
        spi_cmd(2'b01, 8'h88);
      end
      begin
        step();
        host_txn(1'b1, 8'h34, 8'h5C);
      end
    join
    step(4);
    check_eq("no_ovf_when_granted", bus.err_ovf, 0);

    spi_cmd(2'b10, 8'h34);
    exp_acc(1'b0, 1'b0, 8'h34, 8'h00);
    tx_q.push_back(ref_mem[8'h34]);
    spi_cmd(2'b11, 8'h00);
    step(5);
    exp_acc(1'b1, 1'b0, 8'h40, 8'h00);
    hr_q.push_back(ref_mem[8'h40]);
    host_txn(1'b0, 8'h40, 8'h00);
    step(4);

    // Back-to-back 01 while the host owns the RAM: second one dropped
    exp_acc(1'b1, 1'b0, 8'h12, 8'h00);
    hr_q.push_back(ref_mem[8'h12]);
    exp_acc(1'b0, 1'b1, 8'h40, 8'h11);
    fork
      host_txn(1'b0, 8'h12, 8'h00);
      begin
        spi_cmd(2'b01, 8'h11);
        spi_cmd(2'b01, 8'h22);
      end
    join
    step(6);
    check_eq("ovf_set", bus.err_ovf, 1);
    step(5);
    check_eq("ovf_sticky", bus.err_ovf, 1);
    spi_cmd(2'b10, 8'h40);
    exp_acc(1'b0, 1'b0, 8'h40, 8'h00);
    tx_q.push_back(ref_mem[8'h40]);
    spi_cmd(2'b11, 8'h00);
    step(5);

    // Reset during RD of an SPI read: no tx_valid afterwards
    spi_cmd(2'b10, 8'h12);
    exp_acc(1'b0, 1'b0, 8'h12, 8'h00);
    spi_cmd(2'b11, 8'h00);
    step(2);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_rd_reset");
    step(2);
    rst_n = 1'b1;
    step(6);

    // Address registers were cleared: this read targets address 0
    exp_acc(1'b0, 1'b0, 8'h00, 8'h00);
    tx_q.push_back(ref_mem[8'h00]);
    issue = cyc;
    spi_cmd(2'b11, 8'h00);
    step(6);
    check_eq("rd_latency_after_reset", last_tx_cyc - issue, 4);

    check_eq("acc_q_drained", acc_q.size(), 0);
    check_eq("tx_q_drained", tx_q.size(), 0);
    check_eq("hr_q_drained", hr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the RAM data width.
REQ-003 Port clk, input, 1, SHALL be the clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 Port rx_data, input, 10, SHALL carry the SPI-slave word: [9:8] command, [7:0] payload.
REQ-006 Port rx_valid, input, 1, SHALL qualify rx_data for one cycle.
REQ-007 Port tx_data, output, DATA_W, SHALL carry read data returned to the SPI slave.
REQ-008 Port tx_valid, output, 1, SHALL qualify tx_data.
REQ-009 Ports host_req (in, 1), host_we (in, 1), host_addr (in, ADDR_W) and host_wdata (in, DATA_W) SHALL form the local host request.
REQ-010 Ports host_gnt (out, 1), host_rdata (out, DATA_W) and host_rvalid (out, 1) SHALL form the host response.
REQ-011 Ports ram_en, ram_we (out, 1), ram_addr (out, ADDR_W), ram_din (out, DATA_W) and ram_dout (in, DATA_W) SHALL drive a single-port RAM with 1-cycle read latency.
REQ-012 Port err_ovf, output, 1, SHALL be a sticky SPI-overflow flag.

Function
REQ-013 The block SHALL decode commands: 00 latch wr_addr<=payload; 01 SPI write request of payload to wr_addr; 10 latch rd_addr<=payload; 11 SPI read request from rd_addr (payload ignored).
REQ-014 Commands 00/10 SHALL update their address register on the rx_valid cycle in any state, without RAM access.
REQ-015 Commands 01/11 SHALL set a one-deep spi_pend holding the type, address snapshot and data; a later 00/10 SHALL NOT alter a pending request.
REQ-016 An 01/11 arriving while spi_pend is set and not being granted that cycle SHALL be dropped and SHALL set err_ovf.
REQ-017 The FSM SHALL have states IDLE, ACC and RD.
REQ-018 In IDLE with any request present, the block SHALL pick a winner and enter ACC next cycle; IDLE with no request stays IDLE.
REQ-019 In ACC, ram_en=1, ram_we/ram_addr/ram_din SHALL come from the winner, and host_gnt SHALL pulse for exactly this cycle if the host won; the SPI pend SHALL clear here if SPI won.
REQ-020 ACC SHALL go to IDLE for a write and to RD for a read.
REQ-021 In RD, ram_dout SHALL be registered into tx_data (SPI) or host_rdata (host); the matching valid SHALL pulse 1 cycle on the cycle after RD; RD always goes to IDLE.
REQ-022 Latency SHALL be: write, 1 cycle from decision to ram_en; read, 3 cycles from decision to valid.
REQ-023 ram_en/ram_we SHALL be 0 outside ACC; at most one RAM access SHALL occur per cycle.
REQ-024 host_req SHALL be held by the host until host_gnt; dropping it early cancels the request.
REQ-025 tx_data and host_rdata SHALL hold their last value until the next read.

Reset
REQ-026 Asserting rst_n low SHALL immediately force state IDLE, all outputs 0, wr_addr/rd_addr 0, spi_pend 0, err_ovf 0, last-winner = host.
REQ-027 Reset mid-ACC or mid-RD SHALL abort the access with no valid pulse after release.

Configuration
REQ-028 With macro SPI_RAM_ARB_RR_EN defined, simultaneous SPI and host requests SHALL alternate (round-robin on last winner); otherwise SPI SHALL always win.

Verification
REQ-029 00 payload 0x12, then 01 payload 0xA5 -> ACC with ram_we=1, addr 0x12, din 0xA5; no tx_valid.
REQ-030 After REQ-029, 10 payload 0x12, then 11 -> tx_data 0xA5 with tx_valid 3 cycles after the decision.
REQ-031 host_req write 0x34<-0x5C coinciding with an SPI 01 request -> without the macro SPI first, host_gnt next; with it defined, alternation starting with SPI.
REQ-032 Two 01 commands back-to-back while the host holds ACC -> second dropped, err_ovf=1 and held until reset.
REQ-033 rst_n low during RD of an SPI read -> outputs 0, no tx_valid after release, next command is served normally.
